// File: rtl/fa_v1_pkg.sv
// Shared constants and helpers for the fa_v1 adder family.
// Elaboration-time only; no logic, no latency, no backpressure.
package fa_v1_pkg;

    localparam int FA_MIN_WIDTH = 1;
    localparam int FA_MAX_WIDTH = 64;

    function automatic bit width_ok(input int w);
        return (w >= FA_MIN_WIDTH) && (w <= FA_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/fa_v1_cell.sv
// 1-bit combinational full adder cell, the link of the ripple chain.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/fa_v1.sv
// Ripple-carry adder {carry, sum} = a + b + c_in with signed-overflow flag.
// Latency: 1 cycle when REGISTER_OUTPUT=1, otherwise combinational.
// Backpressure: none; accepts one add per cycle, out_valid follows in_valid.
module fa_v1
    import fa_v1_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter bit REGISTER_OUTPUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             out_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("fa_v1: WIDTH must be in 1..64");
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_comb;
    logic             ovf_comb;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s_comb[i]),
            .cout (c[i+1])
        );
    end

    // Carry into the MSB differs from carry out of it exactly on signed overflow.
    assign ovf_comb = c[WIDTH-1] ^ c[WIDTH];

    if (REGISTER_OUTPUT) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum       <= '0;
                carry     <= 1'b0;
                ovf       <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                // Data registers only load on valid, so X on idle inputs is ignored.
                if (in_valid) begin
                    sum   <= s_comb;
                    carry <= c[WIDTH];
                    ovf   <= ovf_comb;
                end
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign sum       = s_comb;
        assign carry     = c[WIDTH];
        assign ovf       = ovf_comb;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_fa_v1.sv
// Directed bench for fa_v1: registered 1-bit and 4-bit instances plus a combinational 1-bit one.
module tb_fa_v1;

    logic clk;
    logic rst_n;

    logic       a1, b1, c1, v1;
    logic       s1, co1, ov1, ov1_vld;

    logic [3:0] a4, b4, s4;
    logic       c4, v4, co4, ov4, ov4_vld;

    logic       ac, bc, cc, vc;
    logic       sc, coc, ovc, ovc_vld;

    int checks;
    int failures;

    fa_v1 #(.WIDTH(1), .REGISTER_OUTPUT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .sum(s1), .carry(co1), .ovf(ov1), .out_valid(ov1_vld),
        .a(a1), .b(b1), .c_in(c1), .in_valid(v1)
    );

    fa_v1 #(.WIDTH(4), .REGISTER_OUTPUT(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .sum(s4), .carry(co4), .ovf(ov4), .out_valid(ov4_vld),
        .a(a4), .b(b4), .c_in(c4), .in_valid(v4)
    );

    fa_v1 #(.WIDTH(1), .REGISTER_OUTPUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .sum(sc), .carry(coc), .ovf(ovc), .out_valid(ovc_vld),
        .a(ac), .b(bc), .c_in(cc), .in_valid(vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        tick();
        tick();
        checks++;
        if ({s1, co1, ov1, ov1_vld} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_w1 got=%b want=0000", {s1, co1, ov1, ov1_vld});
        end
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== 7'b0) begin
            failures++;
            $display("FAIL reset_w4 got=%b want=0000000", {s4, co4, ov4, ov4_vld});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_w1_truth();
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [7:0] exp_o;
        logic [2:0] vec;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        exp_o = 8'b0100_0010;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {a1, b1, c1} = vec;
            v1 = 1'b1;
            tick();
            checks++;
            if ({s1, co1, ov1, ov1_vld} !== {exp_s[i], exp_c[i], exp_o[i], 1'b1}) begin
                failures++;
                $display("FAIL w1_vec%0d got s/c/o/v=%b want=%b", i,
                         {s1, co1, ov1, ov1_vld}, {exp_s[i], exp_c[i], exp_o[i], 1'b1});
            end
        end
        v1 = 1'b0;
        tick();
        checks++;
        if (ov1_vld !== 1'b0) begin
            failures++;
            $display("FAIL w1_valid_drop got=%b want=0", ov1_vld);
        end
    endtask

    task automatic test_w4_overflow();
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== {4'h0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL w4_wrap got=%b want=%b", {s4, co4, ov4, ov4_vld}, {4'h0, 3'b101});
        end
        a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== {4'h8, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL w4_signed_ovf got=%b want=%b", {s4, co4, ov4, ov4_vld}, {4'h8, 3'b011});
        end
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== {4'hF, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL w4_max got=%b want=%b", {s4, co4, ov4, ov4_vld}, {4'hF, 3'b101});
        end
        v4 = 1'b0;
    endtask

    task automatic test_hold();
        a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; v4 = 1'b1;
        tick();
        checks++;
        if ({s4, ov4_vld} !== {4'h7, 1'b1}) begin
            failures++;
            $display("FAIL hold_load got=%b want=%b", {s4, ov4_vld}, {4'h7, 1'b1});
        end
        a4 = 4'h9; b4 = 4'h9; v4 = 1'b0;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== {4'h7, 3'b000}) begin
            failures++;
            $display("FAIL hold_idle got=%b want=%b", {s4, co4, ov4, ov4_vld}, {4'h7, 3'b000});
        end
        a4 = 4'bxxxx; b4 = 4'bxxxx; c4 = 1'bx;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== {4'h7, 3'b000}) begin
            failures++;
            $display("FAIL hold_x_inputs got=%b want=%b", {s4, co4, ov4, ov4_vld}, {4'h7, 3'b000});
        end
    endtask

    task automatic test_reset_mid();
        a4 = 4'h5; b4 = 4'h6; c4 = 1'b0; v4 = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0000000", {s4, co4, ov4, ov4_vld});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({s4, co4, ov4, ov4_vld} !== {4'hB, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", {s4, co4, ov4, ov4_vld}, {4'hB, 3'b011});
        end
        v4 = 1'b0;
    endtask

    task automatic test_comb();
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] vec;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {ac, bc, cc} = vec;
            vc = (i % 2 == 0);
            #1;
            checks++;
            if ({sc, coc, ovc_vld} !== {exp_s[i], exp_c[i], (i % 2 == 0) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL comb_vec%0d got s/c/v=%b want=%b", i, {sc, coc, ovc_vld},
                         {exp_s[i], exp_c[i], (i % 2 == 0) ? 1'b1 : 1'b0});
            end
            #19;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ac = 1'b0; bc = 1'b0; cc = 1'b0; vc = 1'b0;
        test_reset();
        test_w1_truth();
        test_w4_overflow();
        test_hold();
        test_reset_mid();
        test_comb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
